// File: rtl/btn_transition_gen.sv
// btn_transition_gen: synchronises and debounces a raw push-button and emits
// a one-cycle `transition` pulse per press, with optional auto-repeat while
// the button is held. Also reports the debounced level and a release pulse.
//
// Output handshake: `transition` and `release_pulse` are single-cycle strobes
// with no back-pressure; a consumer samples them on every posedge CLK and
// must act on each high cycle. They are never high together, and
// `transition` is never high on two consecutive cycles.
module btn_transition_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_in,
    output logic       transition,
    output logic       pressed,
    output logic       release_pulse,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] PRESS_WAIT   = 3'd1;
    localparam logic [2:0] HELD         = 3'd2;
    localparam logic [2:0] REPEAT       = 3'd3;
    localparam logic [2:0] RELEASE_WAIT = 3'd4;

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    localparam logic BTN_IDLE  = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic REPEAT_ON = (REPEAT_EN != 0);

    // Synchroniser chain plus a registered, active-high button level.
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic btn_s_q, btn_s_d;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          transition_q, transition_d;
    logic          pressed_q, pressed_d;
    logic          release_q, release_d;

    // Next values for the synchroniser and the normalised button level.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        btn_s_d = (BTN_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    end

    // Debounce / repeat state machine; the counter clears on every state change.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        transition_d = 1'b0;
        release_d    = 1'b0;
        pressed_d    = pressed_q;
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d      = HELD;
                    cnt_d        = '0;
                    transition_d = 1'b1;
                    pressed_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_ON && (cnt_q == RD_LAST)) begin
                    state_d      = REPEAT;
                    cnt_d        = '0;
                    transition_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturates when repeat is disabled so the count never wraps.
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REPEAT: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == RP_LAST) begin
                    cnt_d        = '0;
                    transition_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s_q) begin
                    // Release bounce: back to HELD, the repeat delay starts over.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                pressed_d = 1'b0;
            end
        endcase
    end

    // State registers; synchronous active-low reset has priority.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1_q      <= BTN_IDLE;
            sync2_q      <= BTN_IDLE;
            btn_s_q      <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            transition_q <= 1'b0;
            pressed_q    <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            btn_s_q      <= btn_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            transition_q <= transition_d;
            pressed_q    <= pressed_d;
            release_q    <= release_d;
        end
    end

    assign transition    = transition_q;
    assign pressed       = pressed_q;
    assign release_pulse = release_q;
    assign state_dbg     = state_q;

endmodule
